// File: rtl/viterbi_acs_sched.sv
// -----------------------------------------------------------------------------
// viterbi_acs_sched
// Drives a single add-compare-select datapath across all 2^(K-1) trellis states,
// one state per cycle. Each trellis step does the following:
//   * accepts one set of four branch metrics,
//   * sweeps every state through the ACS,
//   * swaps the path-metric buffers,
//   * hands the survivor decisions and the best state/metric to traceback.
//
// Optional feature macro: ACS_SCHED_NORM_EN.
//   When defined, the commit step renormalises the path metrics once the minimum
//   reaches NORM_TH. When undefined, metrics saturate at 15 (INF).
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high (wins over init)
//   init         synchronous metric re-init / abort of an in-flight step
//   bm_valid     branch-metric set valid
//   bm_ready     scheduler idle, a set can be accepted
//   bm_00..bm_11 branch metric for codeword {c0,c1}
//   dec_valid    decision vector valid
//   dec_ready    traceback accepts the decision vector
//   dec          dec[s] = survivor decision for state s
//   best_state   state with minimum new metric (lowest index on tie)
//   best_metric  metric of best_state
//   busy         high while ACS, COMMIT or OUT
// -----------------------------------------------------------------------------
module viterbi_acs_sched #(
    parameter int             K       = 3,
    parameter logic [K-1:0]   G0      = 3'b111,
    parameter logic [K-1:0]   G1      = 3'b101,
    parameter int             NORM_TH = 8,
    localparam int            NSTATES = 1 << (K - 1),
    localparam int            M       = K - 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic               bm_valid,
    output logic               bm_ready,
    input  logic [1:0]         bm_00,
    input  logic [1:0]         bm_01,
    input  logic [1:0]         bm_10,
    input  logic [1:0]         bm_11,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [NSTATES-1:0] dec,
    output logic [M-1:0]       best_state,
    output logic [3:0]         best_metric,
    output logic               busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACS    = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_OUT    = 2'd3;

    localparam logic [3:0]   INF      = 4'd15;
    localparam logic [3:0]   NORM_THV = 4'(NORM_TH);
    localparam logic [M-1:0] LAST_ST  = M'(NSTATES - 1);

`ifdef ACS_SCHED_NORM_EN
    localparam bit NORM_EN = 1'b1;
`else
    localparam bit NORM_EN = 1'b0;
`endif

    logic [1:0]         state_reg;
    logic [M-1:0]       cnt_reg;
    logic [3:0]         bm_reg      [4];
    logic [3:0]         pm_old_reg  [NSTATES];
    logic [3:0]         pm_new_reg  [NSTATES];
    logic [NSTATES-1:0] dec_work_reg;
    logic [3:0]         min_metric_reg;
    logic [M-1:0]       min_state_reg;
    logic [NSTATES-1:0] dec_reg;
    logic [M-1:0]       best_state_reg;
    logic [3:0]         best_metric_reg;

    // ------------------------------------------------------------------
    // ACS datapath for state s = cnt_reg.
    // Branch b comes from predecessor {s[M-2:0], b}. The encoder register
    // seen on that transition is {s, b}, which selects the branch metric.
    // ------------------------------------------------------------------
    logic [3:0]   br_cost [2];
    logic         acs_dec;
    logic [3:0]   acs_cost;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_branch
            logic [K-1:0] enc_r;
            logic [M-1:0] pred;
            logic         c0;
            logic         c1;
            logic [3:0]   pm_sel;
            logic [4:0]   sum;

            assign enc_r  = {cnt_reg, 1'(gi)};
            assign pred   = enc_r[M-1:0];
            assign c0     = ^(enc_r & G0);
            assign c1     = ^(enc_r & G1);
            assign pm_sel = pm_old_reg[pred];
            assign sum    = {1'b0, pm_sel} + {1'b0, bm_reg[{c0, c1}]};
            // An INF predecessor stays INF; otherwise clip at INF.
            assign br_cost[gi] = (pm_sel == INF || sum[4]) ? INF : sum[3:0];
        end
    endgenerate

    // Ties keep branch 0.
    assign acs_dec  = (br_cost[1] < br_cost[0]);
    assign acs_cost = acs_dec ? br_cost[1] : br_cost[0];

    // ------------------------------------------------------------------
    // Commit-time normalisation. INF entries are never reduced.
    // ------------------------------------------------------------------
    logic       norm_apply;
    logic [3:0] pm_commit [NSTATES];

    assign norm_apply = NORM_EN && (min_metric_reg >= NORM_THV);

    generate
        for (gi = 0; gi < NSTATES; gi++) begin : g_norm
            assign pm_commit[gi] = (norm_apply && pm_new_reg[gi] != INF)
                                   ? pm_new_reg[gi] - min_metric_reg
                                   : pm_new_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequencer. rst and init do the same thing: init is simply the
    // frame-start / abort path that is driven during normal operation.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || init) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            dec_work_reg    <= '0;
            min_metric_reg  <= '0;
            min_state_reg   <= '0;
            dec_reg         <= '0;
            best_state_reg  <= '0;
            best_metric_reg <= '0;
            for (int i = 0; i < 4; i++) begin
                bm_reg[i] <= '0;
            end
            for (int i = 0; i < NSTATES; i++) begin
                pm_old_reg[i] <= (i == 0) ? 4'd0 : INF;
                pm_new_reg[i] <= INF;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bm_valid) begin
                        bm_reg[0] <= {2'b00, bm_00};
                        bm_reg[1] <= {2'b00, bm_01};
                        bm_reg[2] <= {2'b00, bm_10};
                        bm_reg[3] <= {2'b00, bm_11};
                        cnt_reg   <= '0;
                        state_reg <= ST_ACS;
                    end
                end
                ST_ACS: begin
                    pm_new_reg[cnt_reg]   <= acs_cost;
                    dec_work_reg[cnt_reg] <= acs_dec;
                    // Strict compare keeps the lowest index on ties.
                    if (cnt_reg == '0 || acs_cost < min_metric_reg) begin
                        min_metric_reg <= acs_cost;
                        min_state_reg  <= cnt_reg;
                    end
                    if (cnt_reg == LAST_ST) begin
                        state_reg <= ST_COMMIT;
                    end else begin
                        cnt_reg <= cnt_reg + M'(1);
                    end
                end
                ST_COMMIT: begin
                    for (int i = 0; i < NSTATES; i++) begin
                        pm_old_reg[i] <= pm_commit[i];
                    end
                    dec_reg         <= dec_work_reg;
                    best_state_reg  <= min_state_reg;
                    best_metric_reg <= norm_apply ? 4'd0 : min_metric_reg;
                    state_reg       <= ST_OUT;
                end
                default: begin
                    if (dec_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bm_ready    = (state_reg == ST_IDLE);
    assign dec_valid   = (state_reg == ST_OUT);
    assign busy        = (state_reg != ST_IDLE);
    assign dec         = dec_reg;
    assign best_state  = best_state_reg;
    assign best_metric = best_metric_reg;

endmodule
